// File: rtl/dct_pkg.sv
// Shared constants and arithmetic helpers for the DCT butterfly stage.
// Index widths are fixed by the 8-point row. The add/sub helpers work at a
// wide internal width. Callers sign-extend into it and truncate back, so the
// result stays exact for any sample width below CALC_W.
package dct_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned ROW_N      = 8;
    localparam int unsigned HALF_N     = 4;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned HIDX_W     = 2;
    localparam int unsigned CALC_W     = 64;

    // Butterfly sum of two sign-extended operands.
    function automatic logic signed [CALC_W-1:0] bfly_sum(
        input logic signed [CALC_W-1:0] a,
        input logic signed [CALC_W-1:0] b
    );
        return a + b;
    endfunction

    // Butterfly difference of two sign-extended operands.
    function automatic logic signed [CALC_W-1:0] bfly_diff(
        input logic signed [CALC_W-1:0] a,
        input logic signed [CALC_W-1:0] b
    );
        return a - b;
    endfunction

endpackage

// File: rtl/dct_row_bank.sv
// Ping-pong row storage: 2 banks x ROW_N samples.
// Ports:
//   clk        rising-edge clock
//   we_i       write strobe
//   wr_bank_i  bank to write
//   wr_idx_i   sample slot to write (0..7)
//   wr_data_i  sample to write
//   rd_bank_i  bank to read
//   rd_idx_i   butterfly index i (0..3)
//   rd_lo_o    x[i] of the read bank (combinational)
//   rd_hi_o    x[7-i] of the read bank (combinational)
module dct_row_bank
    import dct_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              wr_bank_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_bank_i,
    input  logic [HIDX_W-1:0] rd_idx_i,
    output logic [DATA_W-1:0] rd_lo_o,
    output logic [DATA_W-1:0] rd_hi_o
);

    logic [DATA_W-1:0] mem_q [2][ROW_N];

    // Sample storage. No reset: rows are valid only while their full flag is set.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_bank_i][wr_idx_i] <= wr_data_i;
        end
    end

    // For i in 0..3 the mirror slot 7-i is {1, ~i}.
    assign rd_lo_o = mem_q[rd_bank_i][{1'b0, rd_idx_i}];
    assign rd_hi_o = mem_q[rd_bank_i][{1'b1, ~rd_idx_i}];

endmodule

// File: rtl/dct_butterfly_stage.sv
// First butterfly stage of the 8-point 1-D DCT. It collects 8-sample rows into
// a ping-pong buffer. For each stored row it emits s[i]=x[i]+x[7-i] and
// d[i]=x[i]-x[7-i] for i=0..3 through a ready/valid output register.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_data/valid     upstream sample stream
//   in_ready          stage can take a sample (combinational from state)
//   out_sum/out_diff  DATA_W+1 bit signed butterfly results
//   out_idx           butterfly index i
//   out_last          marks the i=3 pair of a row
//   out_valid/ready   downstream handshake
module dct_butterfly_stage
    import dct_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W:0]   out_sum,
    output logic [DATA_W:0]   out_diff,
    output logic [1:0]        out_idx,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned OUT_W = DATA_W + 1;

    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]  wr_idx_q,  wr_idx_d;
    logic [HIDX_W-1:0] rd_idx_q,  rd_idx_d;
    logic [1:0]        full_q,    full_d;

    logic [OUT_W-1:0]  sum_q,  sum_d;
    logic [OUT_W-1:0]  diff_q, diff_d;
    logic [1:0]        idx_q,  idx_d;
    logic              last_q, last_d;
    logic              vld_q,  vld_d;

    logic              wr_fire;
    logic              ld;
    logic signed [DATA_W-1:0] x_lo;
    logic signed [DATA_W-1:0] x_hi;

    dct_row_bank #(.DATA_W(DATA_W)) u_bank (
        .clk       (clk),
        .we_i      (wr_fire),
        .wr_bank_i (wr_bank_q),
        .wr_idx_i  (wr_idx_q),
        .wr_data_i (in_data),
        .rd_bank_i (rd_bank_q),
        .rd_idx_i  (rd_idx_q),
        .rd_lo_o   (x_lo),
        .rd_hi_o   (x_hi)
    );

    // Write/read bookkeeping and output register next state.
    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        full_d    = full_q;
        sum_d     = sum_q;
        diff_d    = diff_q;
        idx_d     = idx_q;
        last_d    = last_q;
        vld_d     = vld_q;

        in_ready = !rst && !full_q[wr_bank_q];
        wr_fire  = in_valid && in_ready;
        ld       = full_q[rd_bank_q] && (!vld_q || out_ready);

        if (wr_fire) begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
            if (wr_idx_q == IDX_W'(ROW_N - 1)) begin
                wr_idx_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end

        // The write bank is never full and the read bank always is, so both
        // flag updates can land in the same cycle without touching the same bit.
        if (ld) begin
            sum_d    = OUT_W'(bfly_sum(CALC_W'(x_lo), CALC_W'(x_hi)));
            diff_d   = OUT_W'(bfly_diff(CALC_W'(x_lo), CALC_W'(x_hi)));
            idx_d    = rd_idx_q;
            last_d   = (rd_idx_q == HIDX_W'(HALF_N - 1));
            vld_d    = 1'b1;
            rd_idx_d = rd_idx_q + HIDX_W'(1);
            if (rd_idx_q == HIDX_W'(HALF_N - 1)) begin
                rd_idx_d          = '0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end else if (vld_q && out_ready) begin
            vld_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            full_q    <= '0;
            sum_q     <= '0;
            diff_q    <= '0;
            idx_q     <= '0;
            last_q    <= 1'b0;
            vld_q     <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            full_q    <= full_d;
            sum_q     <= sum_d;
            diff_q    <= diff_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            vld_q     <= vld_d;
        end
    end

    assign out_sum   = sum_q;
    assign out_diff  = diff_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_dct_butterfly_stage.sv
// Scoreboard bench for dct_butterfly_stage: stimulus pushes expected pairs,
// a negedge monitor pops and compares on every output handshake.
module tb_dct_butterfly_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [32:0] out_sum;
    logic [32:0] out_diff;
    logic [1:0]  out_idx;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    always #5 clk = ~clk;

    typedef struct packed {
        logic [32:0] s;
        logic [32:0] d;
        logic [1:0]  idx;
        logic        last;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          stalls = 0;
    bit          auto_exp = 1'b1;
    bit          gaps     = 1'b0;
    bit          rand_rdy = 1'b0;
    bit          man_rdy  = 1'b1;
    bit          rnd_val  = 1'b1;
    logic [31:0] row [8];
    int          rcnt = 0;

    assign out_ready = rand_rdy ? rnd_val : man_rdy;

    dct_butterfly_stage #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_diff  (out_diff),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Random downstream ready, active only when rand_rdy is set.
    always begin
        @(posedge clk);
        #1;
        rnd_val = 1'($urandom_range(0, 1));
    end

    // Monitor: scoreboard pop on handshake, and hold check after a stalled cycle.
    bit          stall_prev = 1'b0;
    logic [69:0] held;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                total++;
                if ({out_sum, out_diff, out_idx, out_last, out_valid} !== held) begin
                    bad++;
                    $display("FAIL hold: got %h want %h", {out_sum, out_diff, out_idx, out_last, out_valid}, held);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pair: sum=%h diff=%h idx=%0d", out_sum, out_diff, out_idx);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (out_sum !== e.s || out_diff !== e.d || out_idx !== e.idx || out_last !== e.last) begin
                        bad++;
                        $display("FAIL pair: got sum=%h diff=%h idx=%0d last=%0b want sum=%h diff=%h idx=%0d last=%0b",
                                 out_sum, out_diff, out_idx, out_last, e.s, e.d, e.idx, e.last);
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            held = {out_sum, out_diff, out_idx, out_last, out_valid};
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic signed [32:0] s, input logic signed [32:0] d, input int i);
        exp_t e;
        e.s    = s;
        e.d    = d;
        e.idx  = 2'(i);
        e.last = (i == 3);
        q.push_back(e);
    endtask

    task automatic model_row();
        for (int i = 0; i < 4; i++) begin
            logic signed [32:0] a;
            logic signed [32:0] b;
            a = {row[i][31], row[i]};
            b = {row[7-i][31], row[7-i]};
            push_exp(a + b, a - b, i);
        end
    endtask

    // Offer one sample until accepted; record it into the row model.
    task automatic send(input logic [31:0] x);
        bit ok;
        if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            repeat (g) begin
                @(posedge clk);
                #1;
            end
        end
        in_data  = x;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (!ok && c == 0) stalls++;
            if (ok) break;
        end
        in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stayed 0 for sample %h", x);
        end else begin
            row[rcnt] = x;
            rcnt++;
            if (rcnt == 8) begin
                rcnt = 0;
                if (auto_exp) model_row();
            end
        end
    endtask

    task automatic wait_drain(input string nm);
        int c;
        c = 0;
        while ((q.size() != 0 || out_valid) && c < 2000) begin
            @(posedge clk);
            #1;
            c++;
        end
        total++;
        if (c >= 2000) begin
            bad++;
            $display("FAIL %s_drain: pending=%0d want 0", nm, q.size());
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_sum", 64'(out_sum), 0);
        chk("rst_out_diff", 64'(out_diff), 0);
        chk("rst_out_idx", 64'(out_idx), 0);
        chk("rst_out_last", 64'(out_last), 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 64'(in_ready), 1);

        // Row 1..8: hand-computed pairs and first-output latency.
        auto_exp = 1'b0;
        push_exp(9, -7, 0);
        push_exp(9, -5, 1);
        push_exp(9, -3, 2);
        push_exp(9, -1, 3);
        for (int i = 0; i < 8; i++) send(32'(i + 1));
        chk("lat_before", 64'(out_valid), 0);
        @(posedge clk);
        #1;
        chk("lat_first_valid", 64'(out_valid), 1);
        chk("lat_first_idx", 64'(out_idx), 0);
        wait_drain("row1");

        // Extreme operands.
        push_exp(33'h0FFFFFFFE, 33'h000000000, 0);
        push_exp(0, 0, 1);
        push_exp(0, 0, 2);
        push_exp(0, 0, 3);
        push_exp(33'h1FFFFFFFF, 33'h100000001, 0);
        push_exp(0, 0, 1);
        push_exp(0, 0, 2);
        push_exp(0, 0, 3);
        send(32'h7FFFFFFF);
        for (int i = 0; i < 6; i++) send(32'h0);
        send(32'h7FFFFFFF);
        send(32'h80000000);
        for (int i = 0; i < 6; i++) send(32'h0);
        send(32'h7FFFFFFF);
        wait_drain("extreme");
        auto_exp = 1'b1;

        // Backpressure: two rows fill both banks, third row waits.
        man_rdy = 1'b0;
        for (int i = 0; i < 16; i++) send(32'(i * 37 - 200));
        chk("bp_in_ready_low", 64'(in_ready), 0);
        chk("bp_out_valid", 64'(out_valid), 1);
        in_data  = 32'hDEAD0017;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_17th_blocked", 64'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        fork
            begin
                send(32'hDEAD0017);
                for (int i = 1; i < 8; i++) send(32'(i * 1000 + 5));
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                man_rdy = 1'b1;
            end
        join
        wait_drain("backpressure");

        // Continuous stream: in_ready must never drop.
        stalls = 0;
        for (int r = 0; r < 10; r++)
            for (int i = 0; i < 8; i++) send($urandom);
        chk("cont_stalls", 64'(stalls), 0);
        wait_drain("continuous");

        // Random gaps and random downstream ready.
        gaps     = 1'b1;
        rand_rdy = 1'b1;
        for (int r = 0; r < 100; r++)
            for (int i = 0; i < 8; i++) send($urandom);
        gaps     = 1'b0;
        rand_rdy = 1'b0;
        wait_drain("random");

        // Reset with a partial row stored.
        for (int i = 0; i < 5; i++) send(32'h1111_0000 + 32'(i));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_in_ready", 64'(in_ready), 0);
        rst  = 1'b0;
        rcnt = 0;
        chk("rst_mid_out_valid", 64'(out_valid), 0);

        // Reset in the middle of draining a row.
        man_rdy = 1'b0;
        for (int i = 0; i < 8; i++) send(32'h2222_0000 + 32'(i));
        repeat (2) @(posedge clk);
        #1;
        man_rdy = 1'b1;
        @(posedge clk);
        #1;
        man_rdy = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_drain_out_valid", 64'(out_valid), 0);
        rst = 1'b0;
        q.delete();
        rcnt    = 0;
        man_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_stale_output", 64'(out_valid), 0);

        // Fresh row after reset.
        auto_exp = 1'b0;
        push_exp(90, -70, 0);
        push_exp(90, -50, 1);
        push_exp(90, -30, 2);
        push_exp(90, -10, 3);
        for (int i = 0; i < 8; i++) send(32'((i + 1) * 10));
        wait_drain("post_rst");

        chk("queue_empty", 64'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
